// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX byte-stream arbiter.
// rr_pick is sized for up to eight requesters.
package uart_arb_pkg;

  typedef enum logic {
    IDLE,
    PASS
  } state_t;

  localparam int DEF_MAX_MSG_BYTES = 64;
  localparam int DEF_STALL_TIMEOUT = 1024;
  localparam int RR_MAX_REQ = 8;

  // First set bit after ptr, wrapping modulo n.
  // Walk from far to near so the nearest hit is written last.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] valid,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] idx;
    int         j;
    idx = ptr;
    for (int k = RR_MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j[2:0]]) idx = j[2:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search over a request vector.
// Reusable by any arbiter that keeps its own last-grant pointer.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [7:0] v8;
  logic [2:0] p3;
  logic [2:0] pick;

  assign v8    = 8'(valid);
  assign p3    = 3'(ptr);
  assign pick  = rr_pick(v8, p3, N);
  assign found = |valid;
  assign idx   = ID_W'(pick);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX byte port.
// Bytes pass through combinationally while a grant is held.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
  parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 osc_clk,
  input  logic                 osc_reset_,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 trunc_pulse
);

  localparam int BC_W = $clog2(MAX_MSG_BYTES + 1);
  localparam int SC_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_MSG_BYTES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_TIMEOUT - 1);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick;
  logic            found;
  logic [BC_W-1:0] byte_cnt;
  logic [SC_W-1:0] stall_cnt;
  logic [7:0]      lane [NUM_REQ];
  logic            sel_valid;
  logic            sel_last;
  logic            beat;

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[8*i +: 8];
    end
  end

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign busy      = (state == PASS);
  assign tx_valid  = busy & sel_valid;
  assign tx_data   = busy ? lane[grant_id] : 8'h00;
  assign beat      = tx_valid & tx_ready;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = tx_ready;
  end

  always_ff @(posedge osc_clk) begin
    if (osc_reset_) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            state     <= PASS;
          end
        end
        PASS: begin
          if (beat) begin
            byte_cnt  <= byte_cnt + BC_W'(1);
            stall_cnt <= '0;
            // A last byte landing on the size limit is a normal end.
            if (sel_last || byte_cnt == BC_LAST) begin
              state       <= IDLE;
              rr_ptr      <= grant_id;
              trunc_pulse <= ~sel_last;
            end
          end else if (!sel_valid) begin
            if (stall_cnt == SC_LAST) begin
              state       <= IDLE;
              rr_ptr      <= grant_id;
              trunc_pulse <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + SC_W'(1);
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a per-requester byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int STO  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b1;
  logic [1:0]     grant_id;
  logic           busy;
  logic           trunc_pulse;

  int compared = 0;
  int mismatched = 0;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [N][$];
  logic [N-1:0] en = '1;
  int beats [N];
  int seq [$];
  int gorder [$];
  int want [$];
  logic prev_busy = 1'b0;
  logic chk_rdy = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .MAX_MSG_BYTES (MAXB),
    .STALL_TIMEOUT (STO)
  ) dut (
    .osc_clk     (clk),
    .osc_reset_  (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .trunc_pulse (trunc_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_list(string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(tag, (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      req_data[8*i +: 8] = 8'h00;
      req_last[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i] = src_q[i][0][8];
      end
    end
  endtask

  task automatic send(int r, int n, logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      src_q[r].push_back({k == n - 1, base + 8'(k)});
      exp_q[r].push_back(base + 8'(k));
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size() + exp_q[i].size();
    return s;
  endfunction

  // One clock: observe at negedge, retire handshakes at posedge, redrive.
  task automatic step();
    logic [N-1:0] hs;
    logic [7:0]   e;
    logic [8:0]   gone;
    @(negedge clk);
    hs = rst ? '0 : (req_valid & req_ready);
    if (!rst && busy && !prev_busy) gorder.push_back(int'(grant_id));
    prev_busy = busy;
    if (chk_rdy) chk("bp_ready_mirror", 32'(req_ready), 32'({tx_ready, 1'b0}));
    if (!rst && tx_valid && tx_ready) begin
      e = 8'hxx;
      if (exp_q[grant_id].size() > 0) e = exp_q[grant_id].pop_front();
      chk("tx_data", 32'(tx_data), 32'(e));
      chk("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
      beats[grant_id]++;
      seq.push_back(int'(grant_id));
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) gone = src_q[i].pop_front();
    end
    #1;
    drive();
  endtask

  task automatic drain(string tag, int budget);
    for (int c = 0; c < budget && pending() > 0; c++) step();
    chk(tag, pending(), 0);
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    int bp [6];
    drive();
    do_reset(2);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_trunc", trunc_pulse, 0);
    chk("rst_txvalid", tx_valid, 0);

    // single requester
    send(2, 3, 8'h41);
    drive();
    step();
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_nobeat", beats[2], 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t1_beats", beats[2], k);
    end
    chk("t1_release", busy, 0);
    chk("t1_trunc", trunc_pulse, 0);
    step();
    chk("t1_grant_hold", grant_id, 2);

    // round robin from reset
    do_reset(1);
    chk("t2_rst_grant", grant_id, 0);
    seq.delete();
    gorder.delete();
    send(0, 2, 8'h10);
    send(1, 2, 8'h20);
    send(2, 2, 8'h30);
    send(3, 2, 8'h40);
    send(0, 2, 8'h50);
    drive();
    drain("t2_drain", 40);
    want = '{0, 1, 2, 3, 0};
    chk_list("t2_order", gorder, want);
    want = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    chk_list("t2_seq", seq, want);

    // backpressure
    seq.delete();
    send(1, 4, 8'h60);
    drive();
    step();
    chk("t3_grant", grant_id, 1);
    bp = '{1, 0, 0, 1, 1, 1};
    chk_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tx_ready = bp[k][0];
      step();
    end
    chk_rdy = 1'b0;
    want = '{1, 1, 1, 1};
    chk_list("t3_seq", seq, want);
    chk("t3_release", busy, 0);
    chk("t3_last_at_limit", trunc_pulse, 0);
    send(2, 1, 8'h70);
    drive();
    tx_ready = 1'b0;
    repeat (STO + 4) step();
    chk("t3_bp_hold", busy, 1);
    chk("t3_bp_notrunc", trunc_pulse, 0);
    tx_ready = 1'b1;
    step();
    chk("t3_bp_done", busy, 0);

    // truncation at MAX_MSG_BYTES
    seq.delete();
    send(0, 6, 8'h80);
    send(1, 2, 8'h90);
    drive();
    step();
    chk("t4_grant0", grant_id, 0);
    repeat (3) step();
    chk("t4_mid_busy", busy, 1);
    chk("t4_mid_trunc", trunc_pulse, 0);
    step();
    chk("t4_release", busy, 0);
    chk("t4_trunc", trunc_pulse, 1);
    step();
    chk("t4_trunc_once", trunc_pulse, 0);
    chk("t4_grant1", grant_id, 1);
    drain("t4_drain", 20);
    want = '{0, 0, 0, 0, 1, 1, 0, 0};
    chk_list("t4_seq", seq, want);
    chk("t4_end_trunc", trunc_pulse, 0);

    // stall timeout
    seq.delete();
    send(3, 3, 8'hA0);
    send(0, 1, 8'hB0);
    drive();
    step();
    chk("t5_grant3", grant_id, 3);
    step();
    en[3] = 1'b0;
    drive();
    repeat (STO - 1) step();
    chk("t5_stall_hold", busy, 1);
    chk("t5_stall_notrunc", trunc_pulse, 0);
    step();
    chk("t5_timeout_idle", busy, 0);
    chk("t5_timeout_trunc", trunc_pulse, 1);
    step();
    chk("t5_next_grant", grant_id, 0);
    step();
    en[3] = 1'b1;
    drive();
    drain("t5_drain", 20);
    want = '{3, 0, 3, 3};
    chk_list("t5_seq", seq, want);

    // reset mid-message
    seq.delete();
    send(1, 3, 8'hC0);
    drive();
    step();
    chk("t6_grant1", grant_id, 1);
    step();
    rst = 1'b1;
    send(0, 1, 8'hD0);
    drive();
    step();
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_txvalid", tx_valid, 0);
    step();
    chk("t6_rearb", grant_id, 0);
    chk("t6_rearb_busy", busy, 1);
    drain("t6_drain", 20);
    want = '{1, 0, 1, 1};
    chk_list("t6_seq", seq, want);

    chk("sb_empty", pending(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
